// File: rtl/aes_bram_read_arbiter.sv
// Round-robin arbiter sharing one BRAM read port among NUM_REQ AES controllers.
// Serialises requests, returns data/completion to the winner, and force-completes hung reads.
module aes_bram_read_arbiter #(
    parameter int          NUM_REQ        = 2,
    parameter int          GID_W          = 1,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic                 aes_clk,
    input  logic                 aes_rst_n,
    input  logic [NUM_REQ-1:0]   req_start_read,
    input  logic [NUM_REQ*32-1:0] req_bram_addr,
    output logic [NUM_REQ-1:0]   req_bram_complete,
    output logic [31:0]          req_read_data,
    output logic                 bram_start_read,
    output logic [31:0]          bram_addr,
    input  logic                 bram_complete,
    input  logic [31:0]          bram_read_data,
    output logic                 grant_valid,
    output logic [GID_W-1:0]     grant_id,
    output logic                 timeout_err,
    input  logic                 timeout_clr
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RELEASE
    } state_t;

    state_t             state, state_nxt;
    logic [GID_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [GID_W-1:0]   grant_id_nxt;
    logic [31:0]        bram_addr_nxt;
    logic               bram_start_read_nxt;
    logic               grant_valid_nxt;
    logic [NUM_REQ-1:0] req_bram_complete_nxt;
    logic [31:0]        req_read_data_nxt;
    logic [CNT_W-1:0]   tmo_cnt, tmo_cnt_nxt;
    logic               timeout_err_nxt;
    logic               tmo_set;

    logic [2*NUM_REQ-1:0] req_rot;
    logic                 win_found;
    logic [GID_W-1:0]     win_id;
    logic [31:0]          win_addr;
    logic [NUM_REQ-1:0]   grant_onehot;
    int                   win_idx;

    // Rotating the doubled request vector by rr_ptr puts the highest-priority requester at bit 0.
    always_comb begin
        req_rot   = {req_start_read, req_start_read} >> rr_ptr;
        win_found = 1'b0;
        win_id    = '0;
        win_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req_rot[k]) begin
                win_found = 1'b1;
                win_idx   = int'(rr_ptr) + k;
                if (win_idx >= NUM_REQ) begin
                    win_idx = win_idx - NUM_REQ;
                end
                win_id = GID_W'(win_idx);
            end
        end
        win_addr     = req_bram_addr[32*win_id +: 32];
        grant_onehot = NUM_REQ'(1) << grant_id;
    end

    always_comb begin
        state_nxt             = state;
        rr_ptr_nxt            = rr_ptr;
        grant_id_nxt          = grant_id;
        bram_addr_nxt         = bram_addr;
        bram_start_read_nxt   = bram_start_read;
        grant_valid_nxt       = grant_valid;
        req_bram_complete_nxt = req_bram_complete;
        req_read_data_nxt     = req_read_data;
        tmo_cnt_nxt           = tmo_cnt;
        tmo_set               = 1'b0;

        case (state)
            ST_IDLE: begin
                if (win_found) begin
                    grant_id_nxt        = win_id;
                    bram_addr_nxt       = win_addr;
                    bram_start_read_nxt = 1'b1;
                    grant_valid_nxt     = 1'b1;
                    tmo_cnt_nxt         = '0;
                    state_nxt           = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A real completion wins over a timeout landing on the same edge.
                if (bram_complete) begin
                    req_read_data_nxt     = bram_read_data;
                    req_bram_complete_nxt = grant_onehot;
                    bram_start_read_nxt   = 1'b0;
                    state_nxt             = ST_RELEASE;
                end else if (tmo_cnt == CNT_LAST) begin
                    req_read_data_nxt     = TIMEOUT_DATA;
                    req_bram_complete_nxt = grant_onehot;
                    bram_start_read_nxt   = 1'b0;
                    tmo_set               = 1'b1;
                    state_nxt             = ST_RELEASE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                req_bram_complete_nxt = '0;
                grant_valid_nxt       = 1'b0;
                rr_ptr_nxt            = (int'(grant_id) >= NUM_REQ - 1) ? '0 : grant_id + GID_W'(1);
                state_nxt             = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        timeout_err_nxt = tmo_set | (timeout_err & ~timeout_clr);
    end

    always_ff @(posedge aes_clk or negedge aes_rst_n) begin
        if (!aes_rst_n) begin
            state             <= ST_IDLE;
            rr_ptr            <= '0;
            grant_id          <= '0;
            bram_addr         <= '0;
            bram_start_read   <= 1'b0;
            grant_valid       <= 1'b0;
            req_bram_complete <= '0;
            req_read_data     <= '0;
            tmo_cnt           <= '0;
            timeout_err       <= 1'b0;
        end else begin
            state             <= state_nxt;
            rr_ptr            <= rr_ptr_nxt;
            grant_id          <= grant_id_nxt;
            bram_addr         <= bram_addr_nxt;
            bram_start_read   <= bram_start_read_nxt;
            grant_valid       <= grant_valid_nxt;
            req_bram_complete <= req_bram_complete_nxt;
            req_read_data     <= req_read_data_nxt;
            tmo_cnt           <= tmo_cnt_nxt;
            timeout_err       <= timeout_err_nxt;
        end
    end

endmodule

// File: tb/tb_aes_bram_read_arbiter.sv
// Directed scoreboard bench for aes_bram_read_arbiter with four requesters and a short timeout.
// A behavioural BRAM master answers reads after a programmable latency, or hangs on request.
module tb_aes_bram_read_arbiter;

    localparam int          NUM_REQ        = 4;
    localparam int          GID_W          = 2;
    localparam int          TIMEOUT_CYCLES = 8;
    localparam logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF;

    logic                    aes_clk;
    logic                    aes_rst_n;
    logic [NUM_REQ-1:0]      req_start_read;
    logic [NUM_REQ*32-1:0]   req_bram_addr;
    logic [NUM_REQ-1:0]      req_bram_complete;
    logic [31:0]             req_read_data;
    logic                    bram_start_read;
    logic [31:0]             bram_addr;
    logic                    bram_complete  = 1'b0;
    logic [31:0]             bram_read_data = 32'h0;
    logic                    grant_valid;
    logic [GID_W-1:0]        grant_id;
    logic                    timeout_err;
    logic                    timeout_clr;

    logic [31:0] addr_tab [NUM_REQ];
    assign req_bram_addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};

    typedef struct {
        int          id;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   bram_lat = 3;
    bit   bram_hang = 1'b0;
    bit   bram_force = 1'b0;
    int   lat_cnt = 0;

    aes_bram_read_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .GID_W          (GID_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_DATA   (TIMEOUT_DATA)
    ) dut (
        .aes_clk           (aes_clk),
        .aes_rst_n         (aes_rst_n),
        .req_start_read    (req_start_read),
        .req_bram_addr     (req_bram_addr),
        .req_bram_complete (req_bram_complete),
        .req_read_data     (req_read_data),
        .bram_start_read   (bram_start_read),
        .bram_addr         (bram_addr),
        .bram_complete     (bram_complete),
        .bram_read_data    (bram_read_data),
        .grant_valid       (grant_valid),
        .grant_id          (grant_id),
        .timeout_err       (timeout_err),
        .timeout_clr       (timeout_clr)
    );

    initial begin
        aes_clk = 1'b0;
        forever #5 aes_clk = ~aes_clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] bram_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0001;
    endfunction

    // BRAM master model: completes bram_lat cycles after start_read is first seen.
    always @(negedge aes_clk) begin
        if (bram_force) begin
            bram_complete  = 1'b1;
            bram_read_data = 32'h1234_5678;
        end else if (!aes_rst_n || !bram_start_read || bram_hang) begin
            bram_complete = 1'b0;
            lat_cnt       = 0;
        end else begin
            lat_cnt = lat_cnt + 1;
            if (lat_cnt == bram_lat) begin
                bram_complete  = 1'b1;
                bram_read_data = bram_word(bram_addr);
            end else begin
                bram_complete = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] mask);
        req_start_read = mask;
    endtask

    task automatic expectTxn(input int id, input bit tmo);
        exp_t e;
        e.id   = id;
        e.addr = addr_tab[id];
        e.data = tmo ? TIMEOUT_DATA : bram_word(addr_tab[id]);
        e.err  = tmo;
        sb.push_back(e);
    endtask

    // Waits for the next completion pulse and scores it against the oldest expectation.
    task automatic waitComplete(input string tag, input int budget, input bit drop, output int starts);
        exp_t e;
        bit   seen;
        seen   = 1'b0;
        starts = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge aes_clk);
            if (bram_start_read) starts++;
            if (req_bram_complete != '0) seen = 1'b1;
        end
        if (!seen) begin
            checkOutput({tag, "_pulse_seen"}, 32'(seen), 32'd1);
        end else if (sb.size() == 0) begin
            checkOutput({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            checkOutput({tag, "_onehot"}, 32'(req_bram_complete), 32'(1) << e.id);
            checkOutput({tag, "_data"}, req_read_data, e.data);
            checkOutput({tag, "_err"}, 32'(timeout_err), 32'(e.err));
            checkOutput({tag, "_gid"}, 32'(grant_id), 32'(e.id));
            checkOutput({tag, "_addr"}, bram_addr, e.addr);
            checkOutput({tag, "_gv"}, 32'(grant_valid), 32'd1);
            checkOutput({tag, "_start_low"}, 32'(bram_start_read), 32'd0);
            if (drop) req_start_read = req_start_read & ~req_bram_complete;
            @(negedge aes_clk);
            checkOutput({tag, "_pulse_1cyc"}, 32'(req_bram_complete), 32'd0);
            checkOutput({tag, "_gv_low"}, 32'(grant_valid), 32'd0);
        end
    endtask

    initial begin
        int   starts;
        logic regrant;
        aes_rst_n      = 1'b0;
        timeout_clr    = 1'b0;
        req_start_read = '0;
        addr_tab[0]    = 32'h0;
        addr_tab[1]    = 32'h40;
        addr_tab[2]    = 32'h200;
        addr_tab[3]    = 32'h300;
        repeat (3) @(negedge aes_clk);

        checkOutput("rst_start", 32'(bram_start_read), 32'd0);
        checkOutput("rst_gv", 32'(grant_valid), 32'd0);
        checkOutput("rst_cmp", 32'(req_bram_complete), 32'd0);
        checkOutput("rst_gid", 32'(grant_id), 32'd0);
        checkOutput("rst_err", 32'(timeout_err), 32'd0);
        checkOutput("rst_data", req_read_data, 32'd0);
        checkOutput("rst_addr", bram_addr, 32'd0);
        aes_rst_n = 1'b1;

        // Spurious BRAM completion while idle must be ignored.
        @(posedge aes_clk); #1 bram_force = 1'b1;
        @(posedge aes_clk); #1 bram_force = 1'b0;
        @(negedge aes_clk);
        checkOutput("spur_cmp", 32'(req_bram_complete), 32'd0);
        checkOutput("spur_data", req_read_data, 32'd0);
        checkOutput("spur_gv", 32'(grant_valid), 32'd0);
        checkOutput("spur_start", 32'(bram_start_read), 32'd0);

        // Contention: both held high from rr_ptr = 0 alternates 0,1,0,1.
        expectTxn(0, 1'b0); expectTxn(1, 1'b0); expectTxn(0, 1'b0); expectTxn(1, 1'b0);
        applyStimulus(4'b0011);
        for (int t = 0; t < 4; t++) waitComplete($sformatf("cont%0d", t), 20, 1'b0, starts);
        applyStimulus(4'b0000);

        // Single request from rr_ptr = 2 wraps to requester 0.
        addr_tab[0] = 32'h100;
        expectTxn(0, 1'b0);
        applyStimulus(4'b0001);
        waitComplete("single", 20, 1'b1, starts);
        checkOutput("single_start_cycles", 32'(starts), 32'd3);
        repeat (3) @(negedge aes_clk);
        checkOutput("single_hold", req_read_data, bram_word(32'h100));

        // Wrap: grant 2 moves rr_ptr to 3, then 1001 serves 3 then 0, leaving rr_ptr = 1.
        expectTxn(2, 1'b0);
        applyStimulus(4'b0100);
        waitComplete("wrap2", 20, 1'b1, starts);
        expectTxn(3, 1'b0); expectTxn(0, 1'b0);
        applyStimulus(4'b1001);
        waitComplete("wrap3", 20, 1'b1, starts);
        waitComplete("wrap0", 20, 1'b1, starts);
        expectTxn(1, 1'b0); expectTxn(0, 1'b0);
        applyStimulus(4'b0011);
        waitComplete("ptr1", 20, 1'b1, starts);
        waitComplete("ptr0", 20, 1'b1, starts);

        // Abort: requester 2 drops during WAIT, still gets its pulse and is not regranted.
        expectTxn(2, 1'b0);
        applyStimulus(4'b0100);
        for (int i = 0; i < 10 && !bram_start_read; i++) @(negedge aes_clk);
        checkOutput("abort_started", 32'(bram_start_read), 32'd1);
        applyStimulus(4'b0000);
        waitComplete("abort", 20, 1'b0, starts);
        regrant = 1'b0;
        repeat (5) begin
            @(negedge aes_clk);
            regrant = regrant | bram_start_read | grant_valid;
        end
        checkOutput("abort_no_regrant", 32'(regrant), 32'd0);

        // Completion on the timeout edge returns real data without error.
        bram_lat = 8;
        expectTxn(3, 1'b0);
        applyStimulus(4'b1000);
        waitComplete("prio", 30, 1'b1, starts);
        checkOutput("prio_start_cycles", 32'(starts), 32'd8);
        bram_lat = 3;

        // Hung BRAM: forced completion after 8 WAIT cycles.
        bram_hang = 1'b1;
        expectTxn(0, 1'b1);
        applyStimulus(4'b0001);
        waitComplete("tmo", 30, 1'b1, starts);
        checkOutput("tmo_start_cycles", 32'(starts), 32'd8);
        bram_hang = 1'b0;
        repeat (3) @(negedge aes_clk);
        checkOutput("tmo_sticky", 32'(timeout_err), 32'd1);
        checkOutput("tmo_data_hold", req_read_data, TIMEOUT_DATA);
        timeout_clr = 1'b1;
        @(negedge aes_clk);
        timeout_clr = 1'b0;
        checkOutput("tmo_clr", 32'(timeout_err), 32'd0);

        // Reset in WAIT with rr_ptr = 1: abandoned, and arbitration restarts at 0.
        bram_hang = 1'b1;
        applyStimulus(4'b0100);
        for (int i = 0; i < 10 && !bram_start_read; i++) @(negedge aes_clk);
        checkOutput("mid_started", 32'(bram_start_read), 32'd1);
        @(posedge aes_clk);
        #2 aes_rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_start", 32'(bram_start_read), 32'd0);
        checkOutput("mid_rst_gv", 32'(grant_valid), 32'd0);
        checkOutput("mid_rst_cmp", 32'(req_bram_complete), 32'd0);
        applyStimulus(4'b0000);
        bram_hang = 1'b0;
        @(negedge aes_clk);
        aes_rst_n = 1'b1;
        expectTxn(0, 1'b0); expectTxn(1, 1'b0);
        applyStimulus(4'b0011);
        waitComplete("post_rst0", 20, 1'b1, starts);
        waitComplete("post_rst1", 20, 1'b1, starts);

        checkOutput("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/aes_bram_read_arbiter.md
Name: aes_bram_read_arbiter

Overview:
- Round-robin arbiter that shares the single BRAM read port (start_read / addr / complete / read_data handshake) among NUM_REQ AES controllers.
- Sits between the per-engine controllers and the BRAM read master. Allows several AES engines to fetch key/block words from one BRAM.
- Serialises requests, routes data and completion back to the winner, and guards against a hung BRAM with a timeout.

Parameters:
- NUM_REQ, 2, number of requesters (legal 2..8).
- GID_W, 1, grant-index width (must be ≥ clog2(NUM_REQ)).
- TIMEOUT_CYCLES, 1024, WAIT cycles before a transaction is force-completed (≥ 2).
- TIMEOUT_DATA, 32'hDEAD_BEEF, data returned on timeout.

Ports:
- aes_clk  in  1  clock.
- aes_rst_n  in  1  reset, asynchronous, active-low.
- req_start_read  in  NUM_REQ  per-requester read request level.
- req_bram_addr  in  NUM_REQ*32  per-requester byte address; requester i occupies bits [32i+31:32i].
- req_bram_complete  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- req_read_data  out  32  returned word, broadcast to all requesters; valid while req_bram_complete is high.
- bram_start_read  out  1  read request to the BRAM master.
- bram_addr  out  32  address to the BRAM master.
- bram_complete  in  1  BRAM master done strobe.
- bram_read_data  in  32  BRAM read data; valid when bram_complete = 1.
- grant_valid  out  1  a transaction is in flight.
- grant_id  out  GID_W  index of the current or last granted requester.
- timeout_err  out  1  sticky timeout flag.
- timeout_clr  in  1  clears timeout_err.

Behaviour:
- Reset (async assert, sync release) clears all outputs to 0, state = IDLE, rr_ptr = 0, timeout counter = 0. A reset mid-transaction abandons it; no complete pulse is issued.
- States: IDLE, WAIT, RELEASE.
- IDLE:
  - pending = req_start_read.
  - If pending ≠ 0, pick the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - At that edge register grant_id, bram_addr <= the winner's address, bram_start_read <= 1, grant_valid <= 1, timeout counter <= 0, then go to WAIT.
  - bram_complete sampled in IDLE is ignored.
- WAIT:
  - bram_start_read and bram_addr are held stable.
  - On bram_complete = 1: req_read_data <= bram_read_data, req_bram_complete[grant_id] <= 1, bram_start_read <= 0, go to RELEASE.
  - Otherwise increment the counter. When counter == TIMEOUT_CYCLES-1 without bram_complete, act the same but with req_read_data <= TIMEOUT_DATA and timeout_err <= 1.
  - A complete on the same edge as the timeout takes priority: real data is returned, no error.
- RELEASE (exactly 1 cycle): req_bram_complete <= 0, grant_valid <= 0, rr_ptr <= (grant_id+1) mod NUM_REQ, go to IDLE. Requests are not sampled in this state.
- Requester rule: drop req_start_read no later than the edge on which it samples req_bram_complete. A level still high in IDLE after RELEASE is a new request.
- Dropping req_start_read during WAIT does not abort; the transaction completes and the pulse is still delivered.
- Latency: request visible in cycle c → bram_start_read high in c+1. bram_complete in cycle t → req_bram_complete high in t+1. Minimum request-to-complete is 2 cycles.
- Back-to-back grants are spaced by ≥ 3 cycles (IDLE, WAIT ≥ 1, RELEASE).
- Fairness: with all requesters asserted continuously, each is served once per NUM_REQ transactions.
- timeout_err: set has priority over timeout_clr in the same cycle; otherwise timeout_clr = 1 clears it at the next edge.
- req_read_data holds its value between transactions.

Test Plan:
- Single request: req_start_read = 2'b01, addr0 = 0x100, BRAM completes 3 cycles after start with 0xA5A5_0001 → bram_addr = 0x100; bram_start_read high 3 cycles; req_bram_complete = 2'b01 for one cycle; req_read_data = 0xA5A5_0001; grant_id = 0.
- Contention, NUM_REQ = 2: both held high, addr0 = 0x0, addr1 = 0x40, 4 transactions → grant order 0,1,0,1; bram_addr sequence 0x0, 0x40, 0x0, 0x40; each complete pulse reaches only the matching bit.
- Wrap: NUM_REQ = 4, rr_ptr = 3 after a grant to 2, requests 4'b1001 → requester 3 granted next, then 0, then rr_ptr wraps to 1.
- Timeout: TIMEOUT_CYCLES = 8, BRAM never completes → complete pulse after 8 WAIT cycles with req_read_data = 0xDEAD_BEEF and timeout_err = 1; timeout_clr pulse → timeout_err = 0 the next cycle.
- Reset mid-WAIT: assert aes_rst_n = 0 asynchronously → bram_start_read, grant_valid and req_bram_complete go to 0 immediately; after release with requests 2'b10, requester 1 is granted first (rr_ptr = 0, so the search starts at 0 and finds 1).
- Spurious/abort: bram_complete pulsed in IDLE → no output change. Requester drops start_read during WAIT → pulse still delivered on completion; next IDLE does not regrant it.
